parallax_layer_scheduler: RTL and testbench

- Per-scanline sequencer for the parallax VGA renderer, running in the pixel-clock domain.
- Each frame, it advances per-layer horizontal scroll accumulators.
- During each horizontal blank, it fetches one 16-bit line descriptor per layer from a shared single-port descriptor memory over a req/gnt handshake.
- At the start of the active line, it commits the resulting per-layer X offsets atomically to the pixel pipeline.

---
 rtl/parallax_layer_scheduler_pkg.sv | 14 +
 rtl/parallax_scroll_acc.sv | 25 ++
 rtl/parallax_layer_scheduler.sv | 141 ++++++++++++++
 tb/tb_parallax_layer_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/parallax_layer_scheduler_pkg.sv
// parallax_layer_scheduler_pkg: shared state encoding, descriptor fields and default widths
package parallax_layer_scheduler_pkg;
  localparam int NUM_LAYERS_DEF = 4;
  localparam int OFFSET_W_DEF = 10;
  localparam int SPEED_W_DEF = 4;
  localparam int LINE_W_DEF = 9;
  localparam int LAYER_W_DEF = 2;
  localparam int DESC_VIS_BIT = 15;
  localparam int DESC_BIAS_LSB = 0;
  typedef enum logic [2:0] {IDLE, SCROLL, FETCH_REQ, FETCH_DATA, DONE} state_t;
  function automatic logic [15:0] desc_bias(input logic [15:0] d, input int w);
    return (d >> DESC_BIAS_LSB) & 16'((32'h1 << w) - 1);
  endfunction
endpackage

// File: rtl/parallax_scroll_acc.sv
// parallax_scroll_acc: per-layer scroll accumulators with indexed add-speed and read ports
// Ports: clk, rst_n (async active-low); i_add_en/i_add_idx/i_speed add a speed to one layer;
//        i_rd_idx/o_rd_data read one accumulator combinationally.
module parallax_scroll_acc
  import parallax_layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int SPEED_W = SPEED_W_DEF,
  parameter int LAYER_W = LAYER_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_add_en,
  input  logic [LAYER_W-1:0]  i_add_idx,
  input  logic [SPEED_W-1:0]  i_speed,
  input  logic [LAYER_W-1:0]  i_rd_idx,
  output logic [OFFSET_W-1:0] o_rd_data
);
  logic [NUM_LAYERS-1:0][OFFSET_W-1:0] r_acc;
  assign o_rd_data = r_acc[i_rd_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_acc <= '0;
    else if (i_add_en) r_acc[i_add_idx] <= r_acc[i_add_idx] + OFFSET_W'(i_speed);
endmodule

// File: rtl/parallax_layer_scheduler.sv
// parallax_layer_scheduler: per-scanline scroll/descriptor-fetch/commit sequencer for parallax layers
// Ports: clk, rst_n (async active-low); frame_start_i/line_start_i/commit_i timing pulses;
//        speed_i, layer_en_i per-layer config; mem_req_o/mem_addr_o/mem_gnt_i/mem_rdata_i descriptor
//        read port; layer_x_o/layer_vis_o committed results; line_y_o, busy_o, overrun_o/clr_overrun_i status.
// Build option: PARALLAX_SKIP_DISABLED_EN skips the memory fetch of disabled layers.
module parallax_layer_scheduler
  import parallax_layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int SPEED_W = SPEED_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int LAYER_W = LAYER_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start_i,
  input  logic                           line_start_i,
  input  logic                           commit_i,
  input  logic [NUM_LAYERS*SPEED_W-1:0]  speed_i,
  input  logic [NUM_LAYERS-1:0]          layer_en_i,
  output logic                           mem_req_o,
  output logic [LAYER_W+LINE_W-1:0]      mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic [15:0]                    mem_rdata_i,
  output logic [NUM_LAYERS*OFFSET_W-1:0] layer_x_o,
  output logic [NUM_LAYERS-1:0]          layer_vis_o,
  output logic [LINE_W-1:0]              line_y_o,
  output logic                           busy_o,
  output logic                           overrun_o,
  input  logic                           clr_overrun_i
);
  state_t r_state, w_next;
  logic [LAYER_W-1:0] r_idx;
  logic [LINE_W-1:0] r_line_y;
  logic [NUM_LAYERS-1:0][OFFSET_W-1:0] r_shadow_x, r_layer_x;
  logic [NUM_LAYERS-1:0] r_shadow_vis, r_layer_vis;
  logic r_overrun;
  logic [NUM_LAYERS-1:0][SPEED_W-1:0] w_speed;
  logic [OFFSET_W-1:0] w_acc, w_cap_x;
  logic w_busy, w_last, w_skip, w_add, w_cap, w_cap_vis, w_ovr_set;
  logic w_idx_rst, w_idx_inc, w_line_clr, w_line_inc, w_commit;

  assign w_speed = speed_i;
  assign w_busy = r_state inside {SCROLL, FETCH_REQ, FETCH_DATA};
  assign w_last = r_idx == LAYER_W'(NUM_LAYERS - 1);
`ifdef PARALLAX_SKIP_DISABLED_EN
  assign w_skip = r_state == FETCH_REQ && !layer_en_i[r_idx];
`else
  assign w_skip = 1'b0;
`endif
  // req is decoded from state so it stays asserted through an abort cycle and drops on the next edge
  assign mem_req_o = r_state == FETCH_REQ && !w_skip;
  assign mem_addr_o = {r_idx, r_line_y};
  assign w_cap_x = w_skip ? w_acc : w_acc + OFFSET_W'(desc_bias(mem_rdata_i, OFFSET_W));
  assign w_cap_vis = !w_skip && mem_rdata_i[DESC_VIS_BIT] && layer_en_i[r_idx];
  assign w_ovr_set = w_busy && (frame_start_i || line_start_i || commit_i);
  assign layer_x_o = r_layer_x;
  assign layer_vis_o = r_layer_vis;
  assign line_y_o = r_line_y;
  assign busy_o = w_busy;
  assign overrun_o = r_overrun;

  parallax_scroll_acc #(
    .NUM_LAYERS(NUM_LAYERS), .OFFSET_W(OFFSET_W), .SPEED_W(SPEED_W), .LAYER_W(LAYER_W)
  ) u_acc (
    .clk(clk), .rst_n(rst_n), .i_add_en(w_add), .i_add_idx(r_idx),
    .i_speed(w_speed[r_idx]), .i_rd_idx(r_idx), .o_rd_data(w_acc)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // Timing pulses pre-empt the per-state work, so an abort never captures data or adds speed.
  always_comb begin
    w_next = r_state;
    w_add = 1'b0;
    w_cap = 1'b0;
    w_idx_rst = 1'b0;
    w_idx_inc = 1'b0;
    w_line_clr = 1'b0;
    w_line_inc = 1'b0;
    w_commit = 1'b0;
    if (frame_start_i) begin
      w_next = SCROLL;
      w_line_clr = 1'b1;
      w_idx_rst = 1'b1;
    end else if (line_start_i) begin
      w_next = FETCH_REQ;
      w_line_inc = 1'b1;
      w_idx_rst = 1'b1;
    end else if (commit_i && r_state != IDLE) begin
      w_next = IDLE;
      w_commit = r_state == DONE;
    end else begin
      case (r_state)
        SCROLL: begin
          w_add = 1'b1;
          w_next = w_last ? FETCH_REQ : SCROLL;
          w_idx_rst = w_last;
          w_idx_inc = !w_last;
        end
        FETCH_REQ: begin
          w_cap = w_skip;
          w_next = w_skip ? (w_last ? DONE : FETCH_REQ) : (mem_gnt_i ? FETCH_DATA : FETCH_REQ);
          w_idx_inc = w_skip && !w_last;
        end
        FETCH_DATA: begin
          w_cap = 1'b1;
          w_next = w_last ? DONE : FETCH_REQ;
          w_idx_inc = !w_last;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_line_y <= '0;
      r_shadow_x <= '0;
      r_shadow_vis <= '0;
      r_layer_x <= '0;
      r_layer_vis <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_idx <= w_idx_rst ? '0 : w_idx_inc ? r_idx + 1'b1 : r_idx;
      r_line_y <= w_line_clr ? '0 : (w_line_inc && r_line_y != '1) ? r_line_y + 1'b1 : r_line_y;
      if (w_cap) begin
        r_shadow_x[r_idx] <= w_cap_x;
        r_shadow_vis[r_idx] <= w_cap_vis;
      end
      if (w_commit) begin
        r_layer_x <= r_shadow_x;
        r_layer_vis <= r_shadow_vis;
      end
      r_overrun <= w_ovr_set || (r_overrun && !clr_overrun_i);
    end
endmodule

// File: tb/tb_parallax_layer_scheduler.sv
// tb_parallax_layer_scheduler: table-driven and scoreboard checks of parallax_layer_scheduler
module tb_parallax_layer_scheduler;
  logic clk = 0, rst_n = 0, frame_start = 0, line_start = 0, commit = 0, gnt = 1, clr = 0;
  logic [15:0] speed = 0;
  logic [3:0] en = 4'hF;
  logic [15:0] rdata = 16'h0155;
  logic [15:0] desc = 16'h8000;
  logic mem_req, busy, ovr;
  logic [10:0] mem_addr;
  logic [39:0] layer_x;
  logic [3:0] vis;
  logic [8:0] line_y;
  int n_chk = 0, n_fail = 0;
  logic [10:0] grant_q[$];
  typedef struct {logic [39:0] x; logic [3:0] vis;} exp_t;
  exp_t exp_q[$];
  typedef struct {logic [15:0] speed; logic [15:0] desc; logic [3:0] en; logic [39:0] x; logic [3:0] vis;} vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  parallax_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .line_start_i(line_start),
    .commit_i(commit), .speed_i(speed), .layer_en_i(en), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_gnt_i(gnt), .mem_rdata_i(rdata), .layer_x_o(layer_x),
    .layer_vis_o(vis), .line_y_o(line_y), .busy_o(busy), .overrun_o(ovr),
    .clr_overrun_i(clr)
  );

  always @(posedge clk) begin
    logic g;
    logic [10:0] a;
    g = mem_req & gnt;
    a = mem_addr;
    #1;
    if (g) begin
      rdata = desc;
      grant_q.push_back(a);
    end else rdata = 16'h0155;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic f, input logic l, input logic c, input logic k);
    frame_start = f; line_start = l; commit = c; clr = k;
    tick(1);
    frame_start = 0; line_start = 0; commit = 0; clr = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    chk("done_within_budget", 32'(n < 200), 1);
  endtask

  task automatic check_grants(input logic [8:0] y, input logic [3:0] e);
    logic [10:0] ea;
    for (int i = 0; i < 4; i++) begin
`ifdef PARALLAX_SKIP_DISABLED_EN
      if (!e[i]) continue;
`endif
      ea = {2'(i), y};
      if (grant_q.size() == 0) chk("grant_missing", 0, 1);
      else chk("grant_addr", 32'(grant_q.pop_front()), 32'(ea));
    end
    chk("grant_extra", grant_q.size(), 0);
  endtask

  task automatic do_commit(input logic [39:0] x, input logic [3:0] v);
    exp_t e;
    e.x = x;
    e.vis = v;
    exp_q.push_back(e);
    pulse(0, 0, 1, 0);
    e = exp_q.pop_front();
    for (int i = 0; i < 4; i++) chk("layer_x", 32'(layer_x[i*10 +: 10]), 32'(e.x[i*10 +: 10]));
    chk("layer_vis", 32'(vis), 32'(e.vis));
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h4321, 16'h8000, 4'hF, {10'd4, 10'd3, 10'd2, 10'd1}, 4'hF};
    vecs[1] = '{16'h4321, 16'h8005, 4'hF, {10'd13, 10'd11, 10'd9, 10'd7}, 4'hF};
    vecs[2] = '{16'h0000, 16'h83FF, 4'hF, {10'd7, 10'd5, 10'd3, 10'd1}, 4'hF};
    vecs[3] = '{16'hFFFF, 16'h0000, 4'hF, {10'd23, 10'd21, 10'd19, 10'd17}, 4'h0};
    vecs[4] = '{16'h1111, 16'h8000, 4'hA, {10'd24, 10'd22, 10'd20, 10'd18}, 4'hA};
    tick(3);
    chk("rst_layer_x", 32'(layer_x), 0);
    chk("rst_vis", 32'(vis), 0);
    chk("rst_line_y", 32'(line_y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(ovr), 0);
    chk("rst_req", 32'(mem_req), 0);
    rst_n = 1;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      speed = vecs[k].speed;
      desc = vecs[k].desc;
      en = vecs[k].en;
      grant_q.delete();
      pulse(1, 0, 0, 0);
      wait_done();
      check_grants(9'd0, vecs[k].en);
      chk("vec_overrun", 32'(ovr), 0);
      do_commit(vecs[k].x, vecs[k].vis);
    end
    // line_start while DONE restarts without overrun
    en = 4'hF;
    desc = 16'h8000;
    pulse(0, 1, 0, 0);
    chk("line_y_inc", 32'(line_y), 1);
    wait_done();
    grant_q.delete();
    pulse(0, 1, 0, 0);
    chk("done_restart_overrun", 32'(ovr), 0);
    chk("done_restart_line_y", 32'(line_y), 2);
    chk("done_restart_busy", 32'(busy), 1);
    wait_done();
    check_grants(9'd2, 4'hF);
    do_commit({10'd24, 10'd22, 10'd20, 10'd18}, 4'hF);
    // frame and line together: frame wins and SCROLL runs before any request
    pulse(1, 1, 0, 0);
    chk("both_line_y", 32'(line_y), 0);
    chk("both_req", 32'(mem_req), 0);
    n = 0;
    while (!mem_req && n < 20) begin
      tick(1);
      n++;
    end
    chk("scroll_cycles", n, 4);
    wait_done();
    do_commit({10'd25, 10'd23, 10'd21, 10'd19}, 4'hF);
    // commit while stalled on grant
    gnt = 0;
    pulse(0, 1, 0, 0);
    tick(19);
    chk("stall_req", 32'(mem_req), 1);
    chk("stall_addr", 32'(mem_addr), 32'({2'd0, 9'd1}));
    pulse(0, 0, 1, 0);
    chk("abort_req_drop", 32'(mem_req), 0);
    chk("abort_overrun", 32'(ovr), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_x_hold", 32'(layer_x), 32'({10'd25, 10'd23, 10'd21, 10'd19}));
    tick(20);
    gnt = 1;
    chk("overrun_sticky", 32'(ovr), 1);
    pulse(0, 0, 0, 1);
    chk("overrun_clr", 32'(ovr), 0);
    // abort together with clear: set wins
    grant_q.delete();
    gnt = 0;
    pulse(0, 1, 0, 0);
    tick(3);
    pulse(0, 1, 0, 1);
    chk("set_wins", 32'(ovr), 1);
    chk("abort_line_y", 32'(line_y), 3);
    gnt = 1;
    wait_done();
    pulse(0, 0, 0, 1);
    chk("overrun_clr2", 32'(ovr), 0);
    check_grants(9'd3, 4'hF);
    do_commit({10'd25, 10'd23, 10'd21, 10'd19}, 4'hF);
    // accumulator wrap after 70 frames at speed 15
    rst_n = 0;
    tick(1);
    chk("rerst_layer_x", 32'(layer_x), 0);
    rst_n = 1;
    speed = 16'h000F;
    desc = 16'h8000;
    for (int f = 0; f < 70; f++) begin
      grant_q.delete();
      pulse(1, 0, 0, 0);
      wait_done();
      if (f == 69) do_commit({10'd0, 10'd0, 10'd0, 10'd26}, 4'hF);
      else pulse(0, 0, 1, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
